// File: rtl/mem_write_checker_if.sv
// Data-memory write bus plus signature-table config port seen by mem_write_checker.
// The master drives the bus and config; the checker only observes it.
interface mem_write_checker_if #(
    parameter int unsigned DW   = 64,
    parameter int unsigned AW   = 64,
    parameter int unsigned NCHK = 4
);
    localparam int unsigned IW = (NCHK > 1) ? $clog2(NCHK) : 1;

    logic [1:0]    memwrite;
    logic [AW-1:0] dataadr;
    logic [DW-1:0] writedata;
    logic          cfg_we;
    logic [IW-1:0] cfg_idx;
    logic          cfg_en;
    logic [AW-1:0] cfg_adr;
    logic [DW-1:0] cfg_data;

    modport master (
        output memwrite, dataadr, writedata,
        output cfg_we, cfg_idx, cfg_en, cfg_adr, cfg_data
    );

    modport slave (
        input memwrite, dataadr, writedata,
        input cfg_we, cfg_idx, cfg_en, cfg_adr, cfg_data
    );
endinterface

// File: rtl/mem_write_checker.sv
// End-of-test monitor: matches memory writes against a signature table and reports
// PASS/FAIL with a one-cycle halt strobe, a drain delay and a timeout watchdog.
module mem_write_checker #(
    parameter int unsigned DW      = 64,
    parameter int unsigned AW      = 64,
    parameter int unsigned NCHK    = 4,
    parameter int unsigned MODE    = 0,
    parameter int unsigned TIMEOUT = 100,
    parameter int unsigned DRAIN   = 10,
    parameter int unsigned CW      = 32,
    localparam int unsigned IW     = (NCHK > 1) ? $clog2(NCHK) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_write_checker_if.slave   bus,
    output logic [1:0]           state,
    output logic                 pass,
    output logic                 fail,
    output logic                 halt,
    output logic [NCHK-1:0]      hit_mask,
    output logic [IW-1:0]        match_id,
    output logic [CW-1:0]        cycles,
    output logic [CW-1:0]        wr_count
);
    localparam int unsigned DCW = (DRAIN > 1) ? $clog2(DRAIN) : 1;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StDrain = 2'd1,
        StPass  = 2'd2,
        StFail  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [DCW-1:0]  drain_q, drain_d;
    logic            halt_q, halt_d;
    logic [NCHK-1:0] en_q;
    logic [AW-1:0]   adr_q  [NCHK];
    logic [DW-1:0]   data_q [NCHK];
    logic [NCHK-1:0] hit_mask_q, hits, mask_new;
    logic [IW-1:0]   match_id_q, first_id;
    logic [CW-1:0]   cycles_q, wr_count_q;
    logic            wr_any, cfg_ok, pass_cond, timeout_hit, found;

    assign wr_any = (bus.memwrite != 2'b00);
    assign cfg_ok = bus.cfg_we && (32'(bus.cfg_idx) < NCHK);

    // Hits use the table as it stood before this edge, so a same-cycle cfg write
    // never affects the compare.
    always_comb begin
        hits     = '0;
        first_id = '0;
        found    = 1'b0;
        for (int unsigned i = 0; i < NCHK; i++) begin
            hits[i] = wr_any && en_q[i] && (bus.dataadr == adr_q[i]) &&
                      (bus.writedata == data_q[i]);
            if (hits[i] && !found) begin
                first_id = IW'(i);
                found    = 1'b1;
            end
        end
        mask_new = hit_mask_q | hits;
        if (MODE == 0) begin
            pass_cond = |hits;
        end else begin
            pass_cond = (|en_q) && ((mask_new & en_q) == en_q);
        end
        timeout_hit = (TIMEOUT != 0) && (cycles_q == CW'(TIMEOUT - 1));
    end

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            StRun: begin
                if (pass_cond) begin
                    if (DRAIN == 0) begin
                        state_d = StPass;
                    end else begin
                        state_d = StDrain;
                        drain_d = DCW'(DRAIN - 1);
                    end
                end else if (timeout_hit) begin
                    state_d = StFail;
                end
            end
            StDrain: begin
                if (drain_q == '0) begin
                    state_d = StPass;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            default: ;
        endcase
        halt_d = ((state_d == StPass) || (state_d == StFail)) &&
                 ((state_q == StRun) || (state_q == StDrain));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StRun;
            drain_q    <= '0;
            halt_q     <= 1'b0;
            en_q       <= '0;
            hit_mask_q <= '0;
            match_id_q <= '0;
            cycles_q   <= '0;
            wr_count_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            halt_q  <= halt_d;
            if (cfg_ok) begin
                en_q[bus.cfg_idx] <= bus.cfg_en;
            end
            if (state_q == StRun) begin
                hit_mask_q <= mask_new;
                if (pass_cond) begin
                    match_id_q <= first_id;
                end
                if (wr_any && (wr_count_q != '1)) begin
                    wr_count_q <= wr_count_q + 1'b1;
                end
            end
            if (((state_q == StRun) || (state_q == StDrain)) && (cycles_q != '1)) begin
                cycles_q <= cycles_q + 1'b1;
            end
        end
    end

    // Signature payload needs no reset; the enable bits gate every compare.
    always_ff @(posedge clk) begin
        if (cfg_ok) begin
            adr_q[bus.cfg_idx]  <= bus.cfg_adr;
            data_q[bus.cfg_idx] <= bus.cfg_data;
        end
    end

    assign state    = state_q;
    assign pass     = (state_q == StPass);
    assign fail     = (state_q == StFail);
    assign halt     = halt_q;
    assign hit_mask = hit_mask_q;
    assign match_id = match_id_q;
    assign cycles   = cycles_q;
    assign wr_count = wr_count_q;
endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench for mem_write_checker: a MODE 0 and a MODE 1 instance share one bus.
// Outputs are sampled 1 time unit after each rising edge; tcyc mirrors the cycle count.
module tb_mem_write_checker;
    logic clk = 1'b0;
    logic reset;
    int   nchk = 0;
    int   nerr = 0;
    int   tcyc = 0;

    always #5 clk = ~clk;

    mem_write_checker_if #(.DW(64), .AW(64), .NCHK(4)) bus ();

    logic [1:0]  st0, st1;
    logic        pass0, pass1, fail0, fail1, halt0, halt1;
    logic [3:0]  mask0, mask1;
    logic [1:0]  mid0, mid1;
    logic [31:0] cyc0, cyc1, wr0, wr1;

    mem_write_checker #(.MODE(0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus), .state(st0), .pass(pass0), .fail(fail0),
        .halt(halt0), .hit_mask(mask0), .match_id(mid0), .cycles(cyc0), .wr_count(wr0)
    );

    mem_write_checker #(.MODE(1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus), .state(st1), .pass(pass1), .fail(fail1),
        .halt(halt1), .hit_mask(mask1), .match_id(mid1), .cycles(cyc1), .wr_count(wr1)
    );

    typedef struct {
        logic [1:0]  mw;
        logic [63:0] adr;
        logic [63:0] data;
        logic [1:0]  st;
        logic [3:0]  mask;
        logic [31:0] wr;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (!reset) tcyc++;
    endtask

    task automatic idle();
        bus.memwrite = 2'd0;
        bus.cfg_we   = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tcyc  = 0;
    endtask

    task automatic cfg(input logic [1:0] idx, input logic en, input logic [63:0] adr,
                       input logic [63:0] data);
        bus.cfg_idx  = idx;
        bus.cfg_en   = en;
        bus.cfg_adr  = adr;
        bus.cfg_data = data;
        bus.cfg_we   = 1'b1;
        tick();
        bus.cfg_we   = 1'b0;
    endtask

    task automatic wr(input logic [1:0] mw, input logic [63:0] adr, input logic [63:0] data);
        bus.memwrite  = mw;
        bus.dataadr   = adr;
        bus.writedata = data;
        tick();
        bus.memwrite  = 2'd0;
    endtask

    task automatic load_std();
        cfg(2'd0, 1'b1, 64'd100, 64'd7);
        cfg(2'd1, 1'b1, 64'd508, 64'd7);
        cfg(2'd2, 1'b1, 64'd80, 64'd1);
        cfg(2'd3, 1'b1, 64'd320, 64'd4950);
    endtask

    task automatic run_to(input int n);
        while (tcyc < n) tick();
    endtask

    initial begin
        vecs[0] = '{2'd1, 64'd200, 64'd5, 2'd0, 4'b0000, 32'd1};
        vecs[1] = '{2'd0, 64'd80, 64'd1, 2'd0, 4'b0000, 32'd1};
        vecs[2] = '{2'd2, 64'd80, 64'd1, 2'd0, 4'b0100, 32'd2};
        vecs[3] = '{2'd1, 64'd100, 64'd6, 2'd0, 4'b0100, 32'd3};
        vecs[4] = '{2'd1, 64'h8000_0000_0000_0064, 64'd7, 2'd0, 4'b0100, 32'd4};
        vecs[5] = '{2'd1, 64'd100, 64'h1_0000_0007, 2'd0, 4'b0100, 32'd5};
        vecs[6] = '{2'd3, 64'd100, 64'd7, 2'd0, 4'b0101, 32'd6};
        vecs[7] = '{2'd1, 64'd508, 64'd7, 2'd0, 4'b0111, 32'd7};
        vecs[8] = '{2'd1, 64'd320, 64'd4950, 2'd1, 4'b1111, 32'd8};
        vecs[9] = '{2'd1, 64'd200, 64'd5, 2'd1, 4'b1111, 32'd8};

        bus.dataadr = '0; bus.writedata = '0; bus.cfg_idx = '0;
        bus.cfg_en = 1'b0; bus.cfg_adr = '0; bus.cfg_data = '0;
        do_reset();
        chk("rst state", st1, 2'd0);
        chk("rst mask", mask1, 4'b0000);
        chk("rst cycles", cyc1, 32'd0);
        chk("rst wr_count", wr1, 32'd0);
        chk("rst halt", halt1, 1'b0);

        // MODE 1 table walk: all four entries must hit, full-width compares
        load_std();
        for (int i = 0; i < 10; i++) begin
            wr(vecs[i].mw, vecs[i].adr, vecs[i].data);
            chk($sformatf("vec%0d state", i), st1, vecs[i].st);
            chk($sformatf("vec%0d mask", i), mask1, vecs[i].mask);
            chk($sformatf("vec%0d wr_count", i), wr1, vecs[i].wr);
        end
        chk("vec match_id", mid1, 2'd3);

        // MODE 0 pass: write sampled at cycles==19, DRAIN from 20, PASS at 30
        do_reset();
        load_std();
        run_to(19);
        wr(2'd1, 64'd100, 64'd7);
        chk("t1 state", st0, 2'd1);
        chk("t1 mask", mask0, 4'b0001);
        chk("t1 match_id", mid0, 2'd0);
        chk("t1 wr_count", wr0, 32'd1);
        chk("t1 cycles", cyc0, 32'd20);
        repeat (9) tick();
        chk("t1 drain end", st0, 2'd1);
        chk("t1 early halt", halt0, 1'b0);
        tick();
        chk("t1 pass state", st0, 2'd2);
        chk("t1 pass", pass0, 1'b1);
        chk("t1 halt", halt0, 1'b1);
        chk("t1 cycles", cyc0, 32'd30);
        tick();
        chk("t1 halt drop", halt0, 1'b0);
        chk("t1 frozen", cyc0, 32'd30);

        // Timeout: ten non-matching writes, FAIL after cycles==99
        do_reset();
        load_std();
        run_to(10);
        repeat (10) wr(2'd1, 64'd200, 64'd5);
        run_to(99);
        chk("t2 pre state", st0, 2'd0);
        tick();
        chk("t2 state", st0, 2'd3);
        chk("t2 fail", fail0, 1'b1);
        chk("t2 halt", halt0, 1'b1);
        chk("t2 wr_count", wr0, 32'd10);
        chk("t2 mask", mask0, 4'b0000);
        chk("t2 cycles", cyc0, 32'd100);
        tick();
        chk("t2 halt drop", halt0, 1'b0);

        // MODE 1 with entries 0 and 2 only
        do_reset();
        cfg(2'd0, 1'b1, 64'd100, 64'd7);
        cfg(2'd2, 1'b1, 64'd80, 64'd1);
        wr(2'd1, 64'd80, 64'd1);
        chk("t3 state1", st1, 2'd0);
        chk("t3 mask1", mask1, 4'b0100);
        wr(2'd1, 64'd100, 64'd7);
        chk("t3 state2", st1, 2'd1);
        chk("t3 mask2", mask1, 4'b0101);

        // Same-cycle rewrite uses the old entry
        do_reset();
        cfg(2'd0, 1'b1, 64'd100, 64'd7);
        bus.cfg_idx = 2'd0; bus.cfg_en = 1'b1; bus.cfg_adr = 64'd100; bus.cfg_data = 64'd6;
        bus.cfg_we = 1'b1;
        wr(2'd1, 64'd100, 64'd6);
        bus.cfg_we = 1'b0;
        chk("t5 no hit", mask0, 4'b0000);
        chk("t5 state", st0, 2'd0);
        wr(2'd1, 64'd100, 64'd6);
        chk("t5 hit", mask0, 4'b0001);
        chk("t5 drain", st0, 2'd1);

        // Duplicate entries hit together
        do_reset();
        cfg(2'd1, 1'b1, 64'd508, 64'd7);
        cfg(2'd3, 1'b1, 64'd508, 64'd7);
        wr(2'd1, 64'd508, 64'd7);
        chk("t4 mask", mask0, 4'b1010);
        chk("t4 match_id", mid0, 2'd1);
        chk("t4 state", st0, 2'd1);

        // Reset mid-DRAIN
        tick();
        reset = 1'b1;
        tick();
        chk("t6 state", st0, 2'd0);
        chk("t6 pass", pass0, 1'b0);
        chk("t6 fail", fail0, 1'b0);
        chk("t6 halt", halt0, 1'b0);
        chk("t6 mask", mask0, 4'b0000);
        chk("t6 match_id", mid0, 2'd0);
        chk("t6 cycles", cyc0, 32'd0);
        chk("t6 wr_count", wr0, 32'd0);
        reset = 1'b0;
        tcyc  = 0;
        wr(2'd1, 64'd508, 64'd7);
        chk("t6 table off", mask0, 4'b0000);
        chk("t6 still run", st0, 2'd0);
        chk("t6 wr after", wr0, 32'd1);

        // Pass beats timeout on the boundary cycle
        do_reset();
        load_std();
        run_to(99);
        wr(2'd1, 64'd100, 64'd7);
        chk("t7 state", st0, 2'd1);
        chk("t7 fail", fail0, 1'b0);
        chk("t7 halt", halt0, 1'b0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/mem_write_checker.md
Name: mem_write_checker

Overview:
Synthesizable, parametrised self-check monitor for the MIPS core's data-memory write bus. It compares every memory write against a programmable table of NCHK (address, data) pass signatures. It counts cycles and writes, and enforces a timeout watchdog. It reports PASS/FAIL with a halt strobe, so both the simulation bench and on-board runs use the same end-of-test logic.

Parameters:
DW, 64, writedata width
AW, 64, dataadr width
NCHK, 4, number of signature entries (>=1)
MODE, 0, 0 = pass on any enabled entry hit; 1 = pass when all enabled entries have hit
TIMEOUT, 100, cycle budget in RUN before FAIL; 0 disables the watchdog
DRAIN, 10, cycles spent in DRAIN between the pass condition and PASS
CW, 32, width of the cycle and write counters

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high
memwrite  in  2  write enable from the core; any nonzero value is a write
dataadr  in  AW  write address
writedata  in  DW  write data
cfg_we  in  1  load one signature entry
cfg_idx  in  $clog2(NCHK) (min 1)  entry index
cfg_en  in  1  enable bit for the entry
cfg_adr  in  AW  signature address
cfg_data  in  DW  signature data
state  out  2  0=RUN 1=DRAIN 2=PASS 3=FAIL
pass  out  1  high while in PASS
fail  out  1  high while in FAIL
halt  out  1  one-cycle pulse on entry to PASS or FAIL
hit_mask  out  NCHK  sticky per-entry hit flags
match_id  out  $clog2(NCHK) (min 1)  lowest entry index hit on the triggering write
cycles  out  CW  cycles elapsed since reset release
wr_count  out  CW  number of write cycles seen in RUN

Behaviour:
- Reset state: RUN. Outputs: pass=0, fail=0, halt=0, hit_mask=0, match_id=0, cycles=0, wr_count=0. All entry enables cleared; entry adr/data are don't-care.
- Config: when cfg_we=1, entry[cfg_idx] is written at the clock edge. An out-of-range cfg_idx is ignored. Config writes are accepted in every state.
- Match: entry i hits when memwrite!=0, the entry is enabled, dataadr==adr_i and writedata==data_i. Compare is full width with no masking.
- Compares use the table contents from before the clock edge. A cfg write and a matching bus write in the same cycle use the old entry.
- hit_mask |= hits, in RUN only. Hits are sticky until reset.
- Pass condition, evaluated on the post-update mask:
  - MODE 0: any new hit.
  - MODE 1: every enabled entry's hit_mask bit is set, with at least one entry enabled.
- match_id: lowest index among hits in the triggering cycle; it is then held. When several entries hit in one cycle, all of their bits are set.
- wr_count increments on each RUN cycle with memwrite!=0, including the triggering write. It saturates at all-ones.
- cycles increments every cycle in RUN and DRAIN, saturates at all-ones, and freezes in PASS/FAIL.
- FSM transitions:
  - RUN -> DRAIN at the edge where the pass condition holds. With DRAIN=0, go directly to PASS.
  - RUN -> FAIL when TIMEOUT!=0, cycles==TIMEOUT-1 and the pass condition is false in that cycle. Pass takes priority over timeout in the same cycle.
  - DRAIN: a down-counter loaded with DRAIN-1. At zero, go to PASS. Writes, hits and timeout are ignored in DRAIN.
  - PASS and FAIL are terminal until reset.
- halt is high exactly on the first cycle of PASS or FAIL.
- Reset asserted in any state, including mid-DRAIN, returns to the reset state on the next edge.

Test Plan:
- Entries 0..3 = (100,7), (508,7), (80,1), (320,4950), MODE 0. Write 7 to 100 at cycle 20 -> DRAIN, hit_mask=0001, match_id=0. PASS at cycle 30; halt pulses once; cycles frozen at 30.
- Same table, no matching writes. Ten writes of 5 to 200 -> FAIL at cycle 99, halt pulse, wr_count=10, hit_mask=0.
- MODE 1, entries 0 and 2 enabled. Write (80,1) then (100,7) -> stays in RUN after the first write with hit_mask=0100. DRAIN starts after the second write with hit_mask=0101.
- Entries 1 and 3 both set to (508,7). One write of 7 to 508 -> hit_mask=1010, match_id=1.
- cfg_we rewrites entry 0 to (100,6) in the same cycle as a write of 6 to 100 -> no hit. A repeat write one cycle later -> hit.
- Reset pulsed mid-DRAIN -> all outputs return to reset values and the table is disabled. Timeout at the boundary: a matching write at cycle 99 -> DRAIN, not FAIL.
